// File: rtl/mem_access_ctrl.sv
// Load/store access controller: single-beat bus handshake with byte-lane steering and load extension.
// Optional macro MEM_ACCESS_TIMEOUT_EN adds an 8-bit REQ timeout that ends the access in ERR.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        mem_write,
  input  logic [2:0]  load,
  input  logic [1:0]  store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic        fault,
  output logic [31:0] rdata_out,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int unsigned DATA_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;
  localparam logic [1:0] ST_ERR  = 2'd3;

  localparam logic [2:0] LD_LB  = 3'd0;
  localparam logic [2:0] LD_LH  = 3'd1;
  localparam logic [2:0] LD_LW  = 3'd2;
  localparam logic [2:0] LD_LBU = 3'd3;
  localparam logic [2:0] LD_LHU = 3'd4;

  localparam logic [1:0] SO_SW = 2'd0;
  localparam logic [1:0] SO_SB = 2'd1;
  localparam logic [1:0] SO_SH = 2'd2;

  logic [1:0]        state_q, state_d;
  logic              is_store_q, is_store_d;
  logic [2:0]        load_q, load_d;
  logic [1:0]        addr_lo_q, addr_lo_d;
  logic              mem_req_q, mem_req_d;
  logic              mem_we_q, mem_we_d;
  logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [MASK_W-1:0] mem_wmask_q, mem_wmask_d;
  logic              done_q, done_d;
  logic              fault_q, fault_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
  logic [CNT_W-1:0]  cnt_q, cnt_d;
`endif

  logic              legal_c;
  logic              aligned_c;
  logic [MASK_W-1:0] st_mask_c;
  logic [DATA_W-1:0] st_data_c;
  logic [7:0]        ld_byte_c;
  logic [15:0]       ld_half_c;
  logic [DATA_W-1:0] ld_ext_c;

  // Classify the requested access: legal opcode and natural alignment.
  always_comb begin
    legal_c   = 1'b1;
    aligned_c = 1'b1;
    if (mem_write) begin
      case (store)
        SO_SW:   aligned_c = (addr[1:0] == 2'b00);
        SO_SB:   aligned_c = 1'b1;
        SO_SH:   aligned_c = ~addr[0];
        default: legal_c   = 1'b0;
      endcase
    end else begin
      case (load)
        LD_LB, LD_LBU: aligned_c = 1'b1;
        LD_LH, LD_LHU: aligned_c = ~addr[0];
        LD_LW:         aligned_c = (addr[1:0] == 2'b00);
        default:       legal_c   = 1'b0;
      endcase
    end
  end

  // Store lane steering: replicate data across lanes, enable only the addressed bytes.
  always_comb begin
    st_mask_c = 4'b1111;
    st_data_c = wdata;
    case (store)
      SO_SB: begin
        st_mask_c = MASK_W'(4'b0001 << addr[1:0]);
        st_data_c = {4{wdata[7:0]}};
      end
      SO_SH: begin
        st_mask_c = MASK_W'(4'b0011 << addr[1:0]);
        st_data_c = {2{wdata[15:0]}};
      end
      default: begin
        st_mask_c = 4'b1111;
        st_data_c = wdata;
      end
    endcase
  end

  // Load lane select and extension from the latched offset and code.
  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte_c = mem_rdata[7:0];
      2'd1:    ld_byte_c = mem_rdata[15:8];
      2'd2:    ld_byte_c = mem_rdata[23:16];
      default: ld_byte_c = mem_rdata[31:24];
    endcase
    ld_half_c = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (load_q)
      LD_LB:   ld_ext_c = {{24{ld_byte_c[7]}}, ld_byte_c};
      LD_LH:   ld_ext_c = {{16{ld_half_c[15]}}, ld_half_c};
      LD_LBU:  ld_ext_c = {24'h000000, ld_byte_c};
      LD_LHU:  ld_ext_c = {16'h0000, ld_half_c};
      default: ld_ext_c = mem_rdata;
    endcase
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d     = state_q;
    is_store_d  = is_store_q;
    load_d      = load_q;
    addr_lo_d   = addr_lo_q;
    mem_req_d   = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = '0;
    done_d      = 1'b0;
    fault_d     = 1'b0;
    rdata_d     = rdata_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (legal_c && aligned_c) begin
            state_d     = ST_REQ;
            is_store_d  = mem_write;
            load_d      = load;
            addr_lo_d   = addr[1:0];
            mem_req_d   = 1'b1;
            mem_we_d    = mem_write;
            mem_addr_d  = {addr[31:2], 2'b00};
            mem_wdata_d = st_data_c;
            mem_wmask_d = mem_write ? st_mask_c : '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
            cnt_d       = '0;
`endif
          end else begin
            state_d = ST_ERR;
            done_d  = 1'b1;
            fault_d = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (mem_ack) begin
          state_d = ST_RESP;
          done_d  = 1'b1;
          if (!is_store_q) begin
            rdata_d = ld_ext_c;
          end
        end else begin
          mem_req_d   = 1'b1;
          mem_we_d    = mem_we_q;
          mem_wmask_d = mem_wmask_q;
`ifdef MEM_ACCESS_TIMEOUT_EN
          if (cnt_q == {CNT_W{1'b1}}) begin
            state_d     = ST_ERR;
            mem_req_d   = 1'b0;
            mem_we_d    = 1'b0;
            mem_wmask_d = '0;
            done_d      = 1'b1;
            fault_d     = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
`endif
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      is_store_q  <= 1'b0;
      load_q      <= '0;
      addr_lo_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
      done_q      <= 1'b0;
      fault_q     <= 1'b0;
      rdata_q     <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      is_store_q  <= is_store_d;
      load_q      <= load_d;
      addr_lo_q   <= addr_lo_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
      done_q      <= done_d;
      fault_q     <= fault_d;
      rdata_q     <= rdata_d;
`ifdef MEM_ACCESS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  // Stall covers the request cycle in IDLE so the pipeline freezes before the FSM reacts.
  assign stall     = ((state_q == ST_IDLE) && start) || (state_q == ST_REQ);
  assign done      = done_q;
  assign fault     = fault_q;
  assign rdata_out = rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_wmask = mem_wmask_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl against a transaction-level timing/data model.
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        reset, start, mem_write, mem_ack;
  logic [2:0]  load;
  logic [1:0]  store;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, done, fault, mem_req, mem_we;
  logic [31:0] rdata_out, mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  mem_access_ctrl dut (
    .clk(clk), .reset(reset), .start(start), .mem_write(mem_write),
    .load(load), .store(store), .addr(addr), .wdata(wdata),
    .stall(stall), .done(done), .fault(fault), .rdata_out(rdata_out),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", name, cyc, got, exp);
    end
  endtask

  // Current transaction as seen by the model
  bit          cmp_en = 1'b0;
  bit          act = 1'b0;
  bit          ok, flt, is_ld, e_we;
  int          ts = 0;
  int          d = 0;
  logic [31:0] e_addr, e_wdata, e_rdata;
  logic [3:0]  e_mask;
  logic [31:0] model_rdata = 32'h0;

  // Observation counters used by the literal checks
  int          stall_cnt = 0, req_cnt = 0, done_cnt = 0, last_done_cyc = 0;
  logic        last_fault = 1'b0, last_we = 1'b0;
  logic [31:0] last_addr = 32'h0, last_wdata = 32'h0;
  logic [3:0]  last_mask = 4'h0;

  always @(negedge clk) begin : compare
    int p;
    if (cmp_en) begin
      p = cyc - ts;
      if (!act) begin
        chk("idle_stall", 32'(stall), 32'd0);
        chk("idle_req", 32'(mem_req), 32'd0);
        chk("idle_done", 32'(done), 32'd0);
      end else if (p == 0) begin
        chk("p0_stall", 32'(stall), 32'd1);
        chk("p0_req", 32'(mem_req), 32'd0);
        chk("p0_done", 32'(done), 32'd0);
      end else if (ok && p <= d) begin
        chk("req_stall", 32'(stall), 32'd1);
        chk("req_req", 32'(mem_req), 32'd1);
        chk("req_done", 32'(done), 32'd0);
        chk("req_we", 32'(mem_we), 32'(e_we));
        chk("req_addr", mem_addr, e_addr);
        if (e_we) begin
          chk("req_wdata", mem_wdata, e_wdata);
          chk("req_mask", 32'(mem_wmask), 32'(e_mask));
        end
      end else begin
        chk("done_stall", 32'(stall), 32'd0);
        chk("done_req", 32'(mem_req), 32'd0);
        chk("done_done", 32'(done), 32'd1);
        chk("done_fault", 32'(fault), (ok && !flt) ? 32'd0 : 32'd1);
        if (ok && !flt && is_ld) model_rdata = e_rdata;
      end
      chk("rdata_hold", rdata_out, model_rdata);
      if (stall) stall_cnt++;
      if (mem_req) begin
        req_cnt++;
        last_we = mem_we; last_addr = mem_addr; last_wdata = mem_wdata; last_mask = mem_wmask;
      end
      if (done) begin
        done_cnt++; last_done_cyc = cyc; last_fault = fault;
      end
    end
  end

  task automatic scramble();
    mem_write = 1'($urandom); load = 3'($urandom); store = 2'($urandom);
    addr = $urandom; wdata = $urandom;
  endtask

  // Drive one access and set up what the model expects of it.
  task automatic run(input bit mw, input logic [2:0] ld, input logic [1:0] st,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd,
                     input int dl, input int gap, input bit tmo);
    int sz; bit legal; int sh; logic [31:0] v;
    @(posedge clk); #1;
    if (mw) begin legal = (st != 2'd3); sz = (st == 2'd0) ? 4 : (st == 2'd1) ? 1 : 2; end
    else begin legal = (ld <= 3'd4); sz = (ld == 3'd2) ? 4 : (ld == 3'd0 || ld == 3'd3) ? 1 : 2; end
    sh = int'(a[1:0]);
    ok = legal && ((sh % sz) == 0);
    flt = tmo; is_ld = !mw; e_we = mw; d = tmo ? 256 : dl;
    e_addr = a & 32'hFFFF_FFFC;
    e_mask = (sz == 4) ? 4'hF : (sz == 2) ? 4'(3 << sh) : 4'(1 << sh);
    e_wdata = (sz == 4) ? wd : (sz == 2) ? 32'(wd[15:0]) * 32'h0001_0001 : 32'(wd[7:0]) * 32'h0101_0101;
    v = rd >> (8 * sh);
    if (sz == 1) begin v = v & 32'hFF; if (ld == 3'd0 && v[7]) v = v | 32'hFFFF_FF00; end
    else if (sz == 2) begin v = v & 32'hFFFF; if (ld == 3'd1 && v[15]) v = v | 32'hFFFF_0000; end
    else v = rd;
    e_rdata = v;
    ts = cyc; act = 1'b1;
    start = 1'b1; mem_write = mw; load = ld; store = st; addr = a; wdata = wd;
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    if (ok) begin
      for (int i = 1; i <= d; i++) begin
        @(posedge clk); #1;
        scramble();
        mem_ack = (!tmo && i == d);
        mem_rdata = (i == d) ? rd : $urandom;
      end
    end
    @(posedge clk); #1;
    scramble();
    mem_ack = 1'($urandom); mem_rdata = $urandom;
    for (int g = 0; g < gap; g++) begin
      @(posedge clk); #1;
      start = 1'b0; act = 1'b0;
      mem_ack = 1'($urandom); mem_rdata = $urandom;
    end
  endtask

  initial begin
    int s0, r0, dn0;
    reset = 1'b1; start = 1'b0; mem_write = 1'b0; load = 3'd0; store = 2'd0;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_we", 32'(mem_we), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_fault", 32'(fault), 32'd0);
    chk("rst_mask", 32'(mem_wmask), 32'd0);
    chk("rst_rdata", rdata_out, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    reset = 1'b0; cmp_en = 1'b1;

    run(1'b0, 3'd2, 2'd0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1, 1'b0);
    chk("lit_lw_rdata", rdata_out, 32'hDEADBEEF);
    chk("lit_lw_addr", last_addr, 32'h100);
    chk("lit_lw_latency", 32'(last_done_cyc - ts), 32'd2);
    chk("lit_lw_fault", 32'(last_fault), 32'd0);

    run(1'b0, 3'd0, 2'd0, 32'h103, 32'h0, 32'h80123456, 1, 1, 1'b0);
    chk("lit_lb", rdata_out, 32'hFFFFFF80);
    run(1'b0, 3'd3, 2'd0, 32'h103, 32'h0, 32'h80123456, 2, 1, 1'b0);
    chk("lit_lbu", rdata_out, 32'h00000080);

    run(1'b1, 3'd0, 2'd2, 32'h202, 32'h1234ABCD, 32'h0, 1, 1, 1'b0);
    chk("lit_sh_addr", last_addr, 32'h200);
    chk("lit_sh_mask", 32'(last_mask), 32'hC);
    chk("lit_sh_wdata", last_wdata, 32'hABCDABCD);
    chk("lit_sh_we", 32'(last_we), 32'd1);
    chk("lit_sh_rdata_kept", rdata_out, 32'h00000080);

    s0 = stall_cnt; r0 = req_cnt;
    run(1'b0, 3'd2, 2'd0, 32'h101, 32'h0, 32'h0, 1, 1, 1'b0);
    chk("lit_mis_req", 32'(req_cnt - r0), 32'd0);
    chk("lit_mis_stall", 32'(stall_cnt - s0), 32'd1);
    chk("lit_mis_latency", 32'(last_done_cyc - ts), 32'd1);
    chk("lit_mis_fault", 32'(last_fault), 32'd1);

    s0 = stall_cnt; r0 = req_cnt;
    run(1'b0, 3'd2, 2'd0, 32'h104, 32'h0, 32'h0BADF00D, 5, 1, 1'b0);
    chk("lit_dly_stall", 32'(stall_cnt - s0), 32'd6);
    chk("lit_dly_req", 32'(req_cnt - r0), 32'd5);

    // Reset in the middle of REQ aborts the access without a done pulse.
    dn0 = done_cnt;
    @(posedge clk); #1;
    ok = 1'b1; flt = 1'b0; is_ld = 1'b1; e_we = 1'b0; d = 100; e_addr = 32'h300;
    ts = cyc; act = 1'b1;
    start = 1'b1; mem_write = 1'b0; load = 3'd2; addr = 32'h300; mem_ack = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1; cmp_en = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; start = 1'b0; act = 1'b0;
    chk("rst_mid_req", 32'(mem_req), 32'd0);
    chk("rst_mid_rdata", rdata_out, 32'd0);
    model_rdata = 32'h0; cmp_en = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    chk("rst_mid_nodone", 32'(done_cnt - dn0), 32'd0);

    for (int n = 0; n < 300; n++) begin
      run(1'($urandom), 3'($urandom), 2'($urandom), $urandom, $urandom, $urandom,
          int'($urandom_range(1, 6)), int'($urandom_range(0, 2)), 1'b0);
    end
    run(1'b0, 3'd4, 2'd0, 32'h506, 32'h0, 32'h9ABC1234, 3, 2, 1'b0);
    chk("lit_lhu", rdata_out, 32'h00009ABC);

`ifdef MEM_ACCESS_TIMEOUT_EN
    run(1'b0, 3'd2, 2'd0, 32'h400, 32'h0, 32'h0, 1, 2, 1'b1);
    chk("lit_tmo_latency", 32'(last_done_cyc - ts), 32'd257);
    chk("lit_tmo_fault", 32'(last_fault), 32'd1);
`endif

    repeat (2) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
